// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives a req/ack data-memory port for byte-lane loads and stores, handles
// load extension, misalignment and bus timeout, and owns the MEM/WB register.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] alu_result,
  input  logic [63:0] mem_address,
  input  logic [63:0] mem_write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_to_reg,
  input  logic [2:0]  funct3,
  input  logic        reg_write,
  input  logic [4:0]  rd_addr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        mem_stall,
  output logic [63:0] wb_data,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd_addr,
  output logic        exc_misaligned,
  output logic        exc_bus_error
);

  // state | meaning
  // IDLE  | no access in flight; decode EX/MEM, pass non-memory ops straight to MEM/WB
  // BUSY  | request outstanding on dmem, waiting for ack or timeout
  // DONE  | access finished; write result into MEM/WB and release the stall
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {WB_PASS, WB_BUBBLE, WB_MISALIGN, WB_MEM} wb_sel_t;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  state_t           state;
  state_t           state_next;
  wb_sel_t          wb_sel;
  logic             stall_raw;
  logic             start;
  logic             ack_hit;
  logic             timeout_hit;
  logic             mem_op;
  logic             is_store;
  logic             misaligned;
  logic             rd_nonzero;
  logic [2:0]       lane;
  logic [2:0]       lane_q;
  logic [2:0]       f3_q;
  logic [7:0]       size_mask;
  logic [7:0]       wstrb_calc;
  logic [63:0]      wdata_calc;
  logic [63:0]      rdata_shift;
  logic [63:0]      load_ext;
  logic [63:0]      load_q;
  logic [CNT_W-1:0] count_q;
  logic             buserr_q;

  assign mem_op     = mem_read | mem_write;
  assign is_store   = mem_write & ~mem_read;
  assign lane       = mem_address[2:0];
  assign rd_nonzero = |rd_addr;

  always_comb begin
    size_mask  = 8'h01;
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        size_mask  = 8'h01;
        misaligned = 1'b0;
      end
      2'b01: begin
        size_mask  = 8'h03;
        misaligned = mem_address[0];
      end
      2'b10: begin
        size_mask  = 8'h0f;
        misaligned = |mem_address[1:0];
      end
      default: begin
        size_mask  = 8'hff;
        misaligned = |mem_address[2:0];
      end
    endcase
  end

  assign wstrb_calc = is_store ? (size_mask << lane) : 8'h00;
  assign wdata_calc = is_store ? (mem_write_data << {lane, 3'b000}) : 64'd0;

  // Extension uses the captured size/lane, since ack data arrives after IDLE has passed.
  assign rdata_shift = dmem_rdata >> {lane_q, 3'b000};

  always_comb begin
    load_ext = rdata_shift;
    case (f3_q[1:0])
      2'b00: load_ext = f3_q[2] ? {56'd0, rdata_shift[7:0]}
                                : {{56{rdata_shift[7]}}, rdata_shift[7:0]};
      2'b01: load_ext = f3_q[2] ? {48'd0, rdata_shift[15:0]}
                                : {{48{rdata_shift[15]}}, rdata_shift[15:0]};
      2'b10: load_ext = f3_q[2] ? {32'd0, rdata_shift[31:0]}
                                : {{32{rdata_shift[31]}}, rdata_shift[31:0]};
      default: load_ext = rdata_shift;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    stall_raw   = 1'b0;
    start       = 1'b0;
    ack_hit     = 1'b0;
    timeout_hit = 1'b0;
    wb_sel      = WB_BUBBLE;
    case (state)
      IDLE: begin
        if (!mem_op) begin
          wb_sel = WB_PASS;
        end else if (misaligned) begin
          wb_sel = WB_MISALIGN;
        end else begin
          stall_raw  = 1'b1;
          start      = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        stall_raw = 1'b1;
        if (dmem_ack) begin
          ack_hit    = 1'b1;
          state_next = DONE;
        end else if (count_q == CNT_LIMIT) begin
          timeout_hit = 1'b1;
          state_next  = DONE;
        end
      end
      DONE: begin
        wb_sel     = WB_MEM;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stall must drop the moment reset is asserted, even with a memory op still presented.
  assign mem_stall = stall_raw & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 64'd0;
      dmem_wdata <= 64'd0;
      dmem_wstrb <= 8'd0;
      lane_q     <= 3'd0;
      f3_q       <= 3'd0;
      count_q    <= '0;
      load_q     <= 64'd0;
      buserr_q   <= 1'b0;
    end else begin
      if (start) begin
        dmem_req   <= 1'b1;
        dmem_we    <= is_store;
        dmem_addr  <= {mem_address[63:3], 3'b000};
        dmem_wdata <= wdata_calc;
        dmem_wstrb <= wstrb_calc;
        lane_q     <= lane;
        f3_q       <= funct3;
        count_q    <= CNT_W'(1);
        buserr_q   <= 1'b0;
      end
      if (ack_hit) begin
        dmem_req <= 1'b0;
        load_q   <= load_ext;
        buserr_q <= 1'b0;
      end else if (timeout_hit) begin
        dmem_req <= 1'b0;
        buserr_q <= 1'b1;
      end else if (state == BUSY) begin
        count_q <= count_q + CNT_W'(1);
      end
      if (state == DONE) begin
        count_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_data        <= 64'd0;
      wb_reg_write   <= 1'b0;
      wb_rd_addr     <= 5'd0;
      exc_misaligned <= 1'b0;
      exc_bus_error  <= 1'b0;
    end else begin
      case (wb_sel)
        WB_PASS: begin
          wb_data        <= alu_result;
          wb_reg_write   <= reg_write & rd_nonzero;
          wb_rd_addr     <= rd_addr;
          exc_misaligned <= 1'b0;
          exc_bus_error  <= 1'b0;
        end
        WB_MISALIGN: begin
          wb_data        <= mem_address;
          wb_reg_write   <= 1'b0;
          wb_rd_addr     <= rd_addr;
          exc_misaligned <= 1'b1;
          exc_bus_error  <= 1'b0;
        end
        WB_MEM: begin
          wb_data        <= mem_to_reg ? load_q : alu_result;
          wb_reg_write   <= reg_write & ~buserr_q & rd_nonzero;
          wb_rd_addr     <= rd_addr;
          exc_misaligned <= 1'b0;
          exc_bus_error  <= buserr_q;
        end
        default: begin
          wb_reg_write   <= 1'b0;
          exc_misaligned <= 1'b0;
          exc_bus_error  <= 1'b0;
        end
      endcase
    end
  end

endmodule
